// File: rtl/dmio_arbiter.sv
// Two-port round-robin/fixed-priority sequencer in front of the DMIO memory/IO block.
// One access per IDLE->ACCESS->RESP pass; ack pulses in the cycle after the ACCESS-ending edge.
module dmio_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_write,
  output logic              mem_enable_write,
  input  logic [DATA_W-1:0] mem_data_read
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  logic [1:0] state;
  logic       owner;
  logic       last_owner;
  logic       grant_vld;
  logic       grant;

  // On a tie, round-robin hands the grant to the port that did not win last time.
  always_comb begin
    grant_vld = req0 | req1;
    if (req0 && req1)
      grant = (FIXED_PRIO != 0) ? 1'b0 : ~last_owner;
    else
      grant = req1;
  end

  assign busy = (state == ST_ACCESS) || (state == ST_RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      owner            <= 1'b0;
      last_owner       <= 1'b1;
      ack0             <= 1'b0;
      ack1             <= 1'b0;
      rdata0           <= '0;
      rdata1           <= '0;
      mem_address      <= '0;
      mem_data_write   <= '0;
      mem_enable_write <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_vld) begin
            owner            <= grant;
            last_owner       <= grant;
            mem_address      <= grant ? addr1  : addr0;
            mem_data_write   <= grant ? wdata1 : wdata0;
            mem_enable_write <= grant ? we1    : we0;
            state            <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // mem_enable_write still carries the owner's we for this access
          if (!mem_enable_write) begin
            if (owner) rdata1 <= mem_data_read;
            else       rdata0 <= mem_data_read;
          end
          mem_enable_write <= 1'b0;
          ack0             <= ~owner;
          ack1             <= owner;
          state            <= ST_RESP;
        end
        ST_RESP: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          ack0             <= 1'b0;
          ack1             <= 1'b0;
          mem_enable_write <= 1'b0;
          state            <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmio_arbiter.sv
// Bench for dmio_arbiter: directed scenarios plus random two-port traffic
// scored against a transaction-level model of arbitration and memory contents.
module tb_dmio_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam logic [63:0] LEDS_ADDR = 64'h1000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // round-robin instance
  logic          req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, busy, mem_enable_write;
  logic [DW-1:0] rdata0, rdata1, mem_data_write, mem_data_read;
  logic [AW-1:0] mem_address;

  // fixed-priority instance
  logic          f_req0 = 0, f_req1 = 0;
  logic [AW-1:0] f_addr0 = '0, f_addr1 = '0;
  logic          f_ack0, f_ack1, f_busy, f_mem_enable_write;
  logic [DW-1:0] f_rdata0, f_rdata1, f_mem_data_write;
  logic [AW-1:0] f_mem_address;

  dmio_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .mem_address(mem_address), .mem_data_write(mem_data_write),
    .mem_enable_write(mem_enable_write), .mem_data_read(mem_data_read)
  );

  dmio_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1)) u_fp (
    .clk(clk), .rst(rst),
    .req0(f_req0), .req1(f_req1), .we0(1'b0), .we1(1'b0),
    .addr0(f_addr0), .addr1(f_addr1), .wdata0('0), .wdata1('0),
    .ack0(f_ack0), .ack1(f_ack1), .rdata0(f_rdata0), .rdata1(f_rdata1), .busy(f_busy),
    .mem_address(f_mem_address), .mem_data_write(f_mem_data_write),
    .mem_enable_write(f_mem_enable_write), .mem_data_read(~f_mem_address)
  );

  // DMIO stand-in: 64 words plus the LEDS register
  logic [DW-1:0] dmem [0:63];
  logic [DW-1:0] leds;
  logic          mem_init = 1'b0, bd_we = 1'b0;
  logic [5:0]    bd_addr = '0;
  logic [DW-1:0] bd_dat = '0;

  assign mem_data_read = (mem_address == LEDS_ADDR) ? leds :
                         (mem_address < 64)         ? dmem[mem_address[5:0]] : '0;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) dmem[i] <= 64'(i) * 64'h0101_0101;
      leds <= '0;
    end else if (bd_we) begin
      dmem[bd_addr] <= bd_dat;
    end else if (mem_enable_write) begin
      if (mem_address == LEDS_ADDR) leds <= mem_data_write;
      else if (mem_address < 64)    dmem[mem_address[5:0]] <= mem_data_write;
    end
  end

  // reference model state
  logic [DW-1:0] ref_mem [0:63];
  logic [DW-1:0] ref_leds;
  logic [DW-1:0] exp_rd  [2];
  bit            pend    [2];
  bit            p_we    [2];
  logic [AW-1:0] p_addr  [2];
  logic [DW-1:0] p_wd    [2];
  int            last;
  bit            b2b;
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_read(input logic [63:0] a);
    return (a == LEDS_ADDR) ? ref_leds : ref_mem[a[5:0]];
  endfunction

  function automatic logic [63:0] env_read(input logic [63:0] a);
    return (a == LEDS_ADDR) ? leds : dmem[a[5:0]];
  endfunction

  task automatic issue(input int p, input bit w, input logic [63:0] a, input logic [63:0] d);
    pend[p] = 1; p_we[p] = w; p_addr[p] = a; p_wd[p] = d;
    if (p == 0) begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  task automatic retire(input int p);
    pend[p] = 0;
    if (p == 0) req0 = 0; else req1 = 0;
  endtask

  task automatic issue_random(input int p);
    logic [63:0] a;
    a = ($urandom_range(0, 7) == 0) ? LEDS_ADDR : 64'($urandom_range(0, 63));
    issue(p, 1'($urandom_range(0, 1)), a, {$urandom, $urandom});
  endtask

  task automatic wait_ack(output int port, output int cyc, output int pulses, output logic [63:0] wa);
    port = -1; cyc = 0; pulses = 0; wa = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (mem_enable_write) begin pulses++; wa = mem_address; end
      if (ack0 || ack1) begin
        chk("ack_onehot", 64'(ack0 & ack1), 64'd0);
        port = ack1 ? 1 : 0;
        cyc  = c;
        break;
      end
    end
  endtask

  // Predict the winner from pending requests, then score the completed access.
  task automatic complete_one(output int owner);
    int p, cyc, pul, exp_o;
    logic [63:0] wa;
    if (pend[0] && pend[1]) exp_o = (last == 0) ? 1 : 0;
    else                    exp_o = pend[0] ? 0 : 1;
    wait_ack(p, cyc, pul, wa);
    owner = exp_o;
    if (p < 0) begin
      chk("ack_timeout", 64'd0, 64'd1);
      retire(exp_o);
      return;
    end
    chk("owner", 64'(p), 64'(exp_o));
    chk("latency", 64'(cyc), b2b ? 64'd3 : 64'd2);
    owner = p;
    if (p_we[p]) begin
      chk("we_pulses", 64'(pul), 64'd1);
      chk("we_addr", wa, p_addr[p]);
      if (p_addr[p] == LEDS_ADDR) ref_leds = p_wd[p];
      else                        ref_mem[p_addr[p][5:0]] = p_wd[p];
      chk("mem_after_wr", env_read(p_addr[p]), p_wd[p]);
    end else begin
      chk("we_pulses", 64'(pul), 64'd0);
      exp_rd[p] = ref_read(p_addr[p]);
    end
    chk("rdata0", rdata0, exp_rd[0]);
    chk("rdata1", rdata1, exp_rd[1]);
    last = p;
    retire(p);
    b2b = 1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int o, got, cyc;
    rst = 1'b1;
    mem_init = 1'b1;
    for (int i = 0; i < 64; i++) ref_mem[i] = 64'(i) * 64'h0101_0101;
    ref_mem[3] = 64'h55;
    ref_leds = '0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    pend[0] = 0; pend[1] = 0;
    last = 1; b2b = 0;
    @(negedge clk);
    mem_init = 1'b0;
    bd_we = 1'b1; bd_addr = 6'd3; bd_dat = 64'h55;
    @(negedge clk);
    bd_we = 1'b0;

    chk("rst_ack0", 64'(ack0), 64'd0);
    chk("rst_ack1", 64'(ack1), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_we", 64'(mem_enable_write), 64'd0);
    chk("rst_addr", mem_address, 64'd0);
    chk("rst_wdata", mem_data_write, 64'd0);
    chk("rst_rdata0", rdata0, 64'd0);
    chk("rst_rdata1", rdata1, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // single write to LEDS
    issue(0, 1, LEDS_ADDR, 64'd7);
    complete_one(o);
    chk("sw_leds", leds, 64'd7);
    @(negedge clk);
    b2b = 0;
    chk("sw_ack_pulse", 64'(ack0), 64'd0);
    chk("sw_addr_hold", mem_address, LEDS_ADDR);
    chk("sw_data_hold", mem_data_write, 64'd7);

    // single read by port 1 of preloaded word
    issue(1, 0, 64'd3, 64'd0);
    complete_one(o);
    chk("sr_rdata1", rdata1, 64'h55);

    // both ports held: grants must alternate starting with port 0
    issue_random(0);
    issue_random(1);
    for (int i = 0; i < 4; i++) begin
      complete_one(o);
      chk("rr_alt", 64'(o), 64'(i % 2));
      issue_random(o);
    end
    while (pend[0] || pend[1]) complete_one(o);

    // read-after-write across ports
    issue(0, 1, 64'd8, 64'hAB);
    complete_one(o);
    issue(1, 0, 64'd8, 64'd0);
    complete_one(o);
    chk("raw_rdata1", rdata1, 64'hAB);

    // reset during ACCESS of a write
    @(negedge clk);
    issue(0, 1, 64'd5, 64'hDEAD_BEEF);
    @(negedge clk);
    chk("rst_mid_we_before", 64'(mem_enable_write), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_we_async", 64'(mem_enable_write), 64'd0);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_ack0", 64'(ack0), 64'd0);
    retire(0);
    @(negedge clk);
    rst = 1'b0;
    last = 1; b2b = 0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    chk("rst_mid_no_write", env_read(64'd5), ref_read(64'd5));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_mid_no_ack", 64'(ack0 | ack1), 64'd0);
    end
    b2b = 0;

    // random traffic
    for (int it = 0; it < 150; it++) begin
      if (!pend[0] && !pend[1] && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        b2b = 0;
      end
      for (int p = 0; p < 2; p++)
        if (!pend[p] && $urandom_range(0, 1) == 1) issue_random(p);
      if (!pend[0] && !pend[1]) issue_random(int'($urandom_range(0, 1)));
      complete_one(o);
    end
    while (pend[0] || pend[1]) complete_one(o);

    // fixed priority: port 1 starves while req0 stays high
    @(negedge clk);
    f_addr0 = 64'h21; f_addr1 = 64'h33;
    f_req0 = 1; f_req1 = 1;
    for (int t = 0; t < 4; t++) begin
      got = -1; cyc = 0;
      for (int c = 1; c <= 12; c++) begin
        @(negedge clk);
        if (f_ack0 || f_ack1) begin got = f_ack1 ? 1 : 0; cyc = c; break; end
      end
      if (t < 3) begin
        chk("fp_owner", 64'(got), 64'd0);
        chk("fp_rdata0", f_rdata0, ~64'h21);
        if (t == 2) f_req0 = 0;
      end else begin
        chk("fp_owner_after_drop", 64'(got), 64'd1);
        chk("fp_latency", 64'(cyc), 64'd3);
        chk("fp_rdata1", f_rdata1, ~64'h33);
        f_req1 = 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
